// File: rtl/uart_tx_sequencer_if.sv
// uart_tx_sequencer_if: request, buffer-read, byte-stream and completion signals of the TX sequencer
interface uart_tx_sequencer_if #(
  parameter int LEN_W  = 10,
  parameter int ID_W   = 22,
  parameter int ADDR_W = 7
);
  logic              start;
  logic [LEN_W-1:0]  len;
  logic [ID_W-1:0]   task_id;
  logic              abort;
  logic              busy;
  logic              buf_rd;
  logic [ADDR_W-1:0] buf_addr;
  logic [31:0]       buf_data;
  logic [7:0]        tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic              done;
  logic [ID_W-1:0]   done_id;
  logic [LEN_W-1:0]  done_cnt;
  logic              done_abort;
  modport master (
    output start, len, task_id, abort, buf_data, tx_ready,
    input  busy, buf_rd, buf_addr, tx_data, tx_valid, done, done_id, done_cnt, done_abort
  );
  modport slave (
    input  start, len, task_id, abort, buf_data, tx_ready,
    output busy, buf_rd, buf_addr, tx_data, tx_valid, done, done_id, done_cnt, done_abort
  );
endinterface

// File: rtl/uart_tx_sequencer.sv
// uart_tx_sequencer: fetches 32-bit buffer words and streams them little-endian as bytes for one UART frame
module uart_tx_sequencer #(
  parameter int LEN_W   = 10,
  parameter int ID_W    = 22,
  parameter int ADDR_W  = 7,
  parameter int MAX_LEN = 512
) (
  input logic clk,
  input logic rst,
  uart_tx_sequencer_if.slave bus
);
  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] FETCH = 3'd1;
  localparam logic [2:0] WAIT  = 3'd2;
  localparam logic [2:0] SEND  = 3'd3;
  localparam logic [2:0] DONE  = 3'd4;
  logic [2:0]        state;
  logic [ID_W-1:0]   id_q;
  logic [LEN_W-1:0]  eff_len;
  logic [LEN_W-1:0]  cnt;
  logic [LEN_W-1:0]  cnt_nx;
  logic [LEN_W-1:0]  len_c;
  logic [1:0]        lane;
  logic [31:0]       word;
  logic [ADDR_W-1:0] addr;
  logic [ID_W-1:0]   done_id_q;
  logic [LEN_W-1:0]  done_cnt_q;
  logic              done_abort_q;
  logic              hs;
  logic              active;
  assign len_c  = (bus.len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : bus.len;
  assign hs     = (state == SEND) && bus.tx_ready;
  assign cnt_nx = cnt + LEN_W'(hs);
  assign active = (state == FETCH) || (state == WAIT) || (state == SEND);
  assign bus.busy       = state != IDLE;
  assign bus.buf_rd     = state == FETCH;
  assign bus.buf_addr   = addr;
  assign bus.tx_data    = word[{lane, 3'b000} +: 8];
  assign bus.tx_valid   = state == SEND;
  assign bus.done       = state == DONE;
  assign bus.done_id    = done_id_q;
  assign bus.done_cnt   = done_cnt_q;
  assign bus.done_abort = done_abort_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      id_q         <= '0;
      eff_len      <= '0;
      cnt          <= '0;
      lane         <= '0;
      word         <= '0;
      addr         <= '0;
      done_id_q    <= '0;
      done_cnt_q   <= '0;
      done_abort_q <= 1'b0;
    end else if (active && bus.abort) begin
      // a byte handshaken in the abort cycle still counts
      state        <= DONE;
      cnt          <= cnt_nx;
      done_id_q    <= id_q;
      done_cnt_q   <= cnt_nx;
      done_abort_q <= 1'b1;
    end else begin
      case (state)
        IDLE: if (bus.start) begin
          id_q    <= bus.task_id;
          eff_len <= len_c;
          cnt     <= '0;
          lane    <= '0;
          addr    <= '0;
          if (len_c == '0) begin
            state        <= DONE;
            done_id_q    <= bus.task_id;
            done_cnt_q   <= '0;
            done_abort_q <= 1'b0;
          end else begin
            state <= FETCH;
          end
        end
        FETCH: state <= WAIT;
        WAIT: begin
          word  <= bus.buf_data;
          state <= SEND;
        end
        SEND: if (hs) begin
          cnt <= cnt_nx;
          if (cnt_nx == eff_len) begin
            state        <= DONE;
            done_id_q    <= id_q;
            done_cnt_q   <= cnt_nx;
            done_abort_q <= 1'b0;
          end else if (lane == 2'd3) begin
            lane  <= '0;
            addr  <= addr + ADDR_W'(1);
            state <= FETCH;
          end else begin
            lane <= lane + 2'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_sequencer.sv
// tb_uart_tx_sequencer: scoreboard bench for uart_tx_sequencer with a modelled buffer memory
module tb_uart_tx_sequencer;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  uart_tx_sequencer_if bus ();
  uart_tx_sequencer dut (.clk(clk), .rst(rst), .bus(bus));
  logic [31:0] mem [128];
  always @(posedge clk) if (bus.buf_rd) bus.buf_data <= mem[bus.buf_addr];
  logic [7:0]  exp_b [$];
  logic [32:0] exp_d [$];
  int n_tests = 0;
  int n_fail  = 0;
  int rd_cnt = 0, valid_cnt = 0, done_n = 0;
  int last_addr = 0;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  always @(negedge clk) if (!rst) begin
    if (bus.buf_rd) begin
      rd_cnt++;
      last_addr = int'(bus.buf_addr);
    end
    if (bus.tx_valid) valid_cnt++;
    if (bus.tx_valid && bus.tx_ready) begin
      if (exp_b.size() == 0) chk("byte_queue", 64'(exp_b.size()), 64'd1);
      else chk("tx_byte", 64'(bus.tx_data), 64'(exp_b.pop_front()));
    end
    if (bus.done) begin
      done_n++;
      if (exp_d.size() == 0) chk("done_queue", 64'(exp_d.size()), 64'd1);
      else chk("done_rec", 64'({bus.done_id, bus.done_cnt, bus.done_abort}), 64'(exp_d.pop_front()));
    end
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic go(input logic [9:0] l, input logic [21:0] id);
    bus.len = l;
    bus.task_id = id;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
  endtask
  task automatic wait_done(input int maxc);
    int n0;
    n0 = done_n;
    for (int i = 0; i < maxc && done_n == n0; i++) step();
    chk("done_seen", 64'(done_n != n0), 64'd1);
  endtask
  task automatic wait_33();
    for (int i = 0; i < 50 && !(bus.tx_valid && bus.tx_data == 8'h33); i++) step();
    chk("see_33", 64'(bus.tx_valid && bus.tx_data == 8'h33), 64'd1);
  endtask
  task automatic check_zero(input string tag);
    chk({tag, "_ctl"}, 64'({bus.busy, bus.buf_rd, bus.tx_valid, bus.done, bus.done_abort}), 64'd0);
    chk({tag, "_dat"}, 64'({bus.buf_addr, bus.tx_data}), 64'd0);
    chk({tag, "_rec"}, 64'({bus.done_id, bus.done_cnt}), 64'd0);
  endtask
  task automatic load_basic();
    mem[0] = 32'h44332211;
    mem[1] = 32'h88776655;
  endtask
  task automatic push5();
    exp_b.push_back(8'h11); exp_b.push_back(8'h22); exp_b.push_back(8'h33);
    exp_b.push_back(8'h44); exp_b.push_back(8'h55);
  endtask
  initial begin
    int rd0, v0;
    logic [7:0] b;
    rst = 1'b1;
    bus.start = 1'b0; bus.len = '0; bus.task_id = '0; bus.abort = 1'b0; bus.tx_ready = 1'b1;
    for (int i = 0; i < 128; i++) mem[i] = '0;
    repeat (3) step();
    check_zero("reset");
    rst = 1'b0;
    step();
    // basic frame with latency checks
    mem[0] = 32'h44332211;
    mem[1] = 32'h00000055;
    rd0 = rd_cnt;
    push5();
    exp_d.push_back({22'h2A, 10'd5, 1'b0});
    go(10'd5, 22'h2A);
    chk("lat_rd", 64'({bus.buf_rd, bus.buf_addr}), 64'({1'b1, 7'd0}));
    step();
    chk("lat_wait", 64'({bus.buf_rd, bus.tx_valid}), 64'd0);
    step();
    chk("lat_valid", 64'({bus.tx_valid, bus.tx_data}), 64'({1'b1, 8'h11}));
    wait_done(50);
    chk("basic_rds", 64'(rd_cnt - rd0), 64'd2);
    chk("basic_last_addr", 64'(last_addr), 64'd1);
    step();
    chk("basic_hold", 64'({bus.done, bus.busy, bus.done_cnt}), 64'({1'b0, 1'b0, 10'd5}));
    // zero length
    rd0 = rd_cnt;
    v0 = valid_cnt;
    exp_d.push_back({22'h3, 10'd0, 1'b0});
    go(10'd0, 22'h3);
    chk("zero_done_c1", 64'(bus.done), 64'd1);
    wait_done(5);
    repeat (3) step();
    chk("zero_no_rd", 64'(rd_cnt - rd0), 64'd0);
    chk("zero_no_valid", 64'(valid_cnt - v0), 64'd0);
    // clamp to 512 bytes
    for (int k = 0; k < 512; k++) begin
      b = 8'((k * 7 + 3) ^ (k >> 8));
      mem[k / 4][8 * (k % 4) +: 8] = b;
      exp_b.push_back(b);
    end
    rd0 = rd_cnt;
    exp_d.push_back({22'h3FFFFF, 10'd512, 1'b0});
    go(10'd1000, 22'h3FFFFF);
    wait_done(2000);
    chk("clamp_rds", 64'(rd_cnt - rd0), 64'd128);
    chk("clamp_last_addr", 64'(last_addr), 64'd127);
    step();
    // backpressure with an ignored start
    load_basic();
    push5();
    exp_d.push_back({22'h15, 10'd5, 1'b0});
    go(10'd5, 22'h15);
    wait_33();
    bus.tx_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      bus.start = (i == 0);
      bus.len = 10'd3;
      bus.task_id = 22'h77;
      step();
      bus.start = 1'b0;
      chk("stall_hold", 64'({bus.tx_valid, bus.tx_data}), 64'({1'b1, 8'h33}));
    end
    bus.tx_ready = 1'b1;
    wait_done(50);
    repeat (6) step();
    chk("stall_idle", 64'({bus.busy, bus.done_id}), 64'({1'b0, 22'h15}));
    // abort on the handshake of 0x33
    exp_b.push_back(8'h11); exp_b.push_back(8'h22); exp_b.push_back(8'h33);
    exp_d.push_back({22'h99, 10'd3, 1'b1});
    go(10'd8, 22'h99);
    wait_33();
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;
    chk("abort_done", 64'({bus.done, bus.done_abort, bus.done_cnt, bus.tx_valid}), 64'({1'b1, 1'b1, 10'd3, 1'b0}));
    step();
    chk("abort_after", 64'({bus.tx_valid, bus.busy, bus.done_abort}), 64'({1'b0, 1'b0, 1'b1}));
    // reset mid-frame then a short frame
    bus.tx_ready = 1'b0;
    go(10'd5, 22'h55);
    for (int i = 0; i < 20 && !bus.tx_valid; i++) step();
    chk("rst_in_send", 64'(bus.tx_valid), 64'd1);
    rst = 1'b1;
    step();
    check_zero("midrst");
    rst = 1'b0;
    bus.tx_ready = 1'b1;
    exp_b.push_back(8'h11); exp_b.push_back(8'h22);
    exp_d.push_back({22'h66, 10'd2, 1'b0});
    go(10'd2, 22'h66);
    wait_done(30);
    repeat (3) step();
    chk("queues_empty", 64'(exp_b.size() + exp_d.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/uart_tx_sequencer.md
Name: uart_tx_sequencer

Overview:
Sequences transmission of one UART frame from the 512-byte transmit buffer of the UART device into a byte-serial transmitter.
- A write to the transmit control register (task id + length) produces a start pulse.
- The block fetches 32-bit buffer words and unpacks them little-endian into bytes.
- It streams the bytes over a valid/ready handshake, then reports completion with the task id so the bus side can acknowledge the blocking write.

Parameters:
LEN_W, 10, width of length field (bytes)
ID_W, 22, width of task id field
ADDR_W, 7, word address width into transmit half of buffer (128 words)
MAX_LEN, 512, maximum bytes per frame; larger requests clamp to this

Ports:
clk  in  1  system clock, all logic rising-edge
rst  in  1  synchronous active-high reset
start  in  1  one-cycle request; sampled only in IDLE
len  in  LEN_W  byte count, sampled with start
task_id  in  ID_W  task id, sampled with start
abort  in  1  terminate current frame
busy  out  1  high in any state other than IDLE
buf_rd  out  1  buffer read strobe
buf_addr  out  ADDR_W  buffer word address
buf_data  in  32  buffer read data, valid 1 cycle after buf_rd
tx_data  out  8  byte to transmitter
tx_valid  out  1  tx_data valid
tx_ready  in  1  transmitter accepts byte when tx_valid&&tx_ready
done  out  1  one-cycle completion pulse
done_id  out  ID_W  task id of completed frame, held until next done
done_cnt  out  LEN_W  bytes actually accepted, held until next done
done_abort  out  1  frame ended by abort, held until next done

Behaviour:
- Reset (rst=1 at a clock edge) has priority over everything, including mid-frame:
  - State goes to IDLE.
  - busy, buf_rd, tx_valid, done and done_abort are 0.
  - buf_addr, tx_data, done_id and done_cnt are 0.
  - Internal counters are cleared.
- States: IDLE, FETCH, WAIT, SEND, DONE.
- IDLE:
  - On start: latch task_id and eff_len = min(len, MAX_LEN).
  - If eff_len==0, go to DONE; otherwise go to FETCH with word address 0, byte count 0 and lane 0.
  - start outside IDLE is ignored (no queuing).
- FETCH: buf_rd=1 for exactly one cycle with buf_addr = current word address; next state WAIT.
- WAIT: latch buf_data into the word register at the end of this cycle; next state SEND.
- SEND:
  - tx_valid=1 and tx_data = word[8*lane+7 : 8*lane]; lane 0 is bits 7:0.
  - tx_data and tx_valid stay stable while tx_ready=0.
  - On handshake, increment the byte count, then:
    - if count+1 == eff_len, go to DONE;
    - else if lane==3, set lane=0, word address +1, go to FETCH;
    - else lane+1 and stay in SEND.
- DONE:
  - done=1 for one cycle.
  - done_id = latched id, done_cnt = byte count, done_abort = abort flag.
  - Next state IDLE; busy falls in the same cycle done is seen.
- Latency:
  - start at cycle 0 puts buf_rd high in cycle 1 and tx_valid high in cycle 3.
  - Each word boundary costs 2 idle cycles (FETCH, WAIT) between handshakes.
  - With len==0, done is high in cycle 1.
- abort:
  - Ignored in IDLE and DONE.
  - In FETCH, WAIT or SEND it forces DONE next cycle with done_abort=1.
  - In SEND, if abort and a handshake occur in the same cycle, the byte counts; done_cnt includes it.
  - After abort, tx_valid deasserts the following cycle.
- Word address never exceeds MAX_LEN/4-1 (127); no wrap-around is possible because of clamping.
- done_cnt width: a value of 512 fits in LEN_W=10.

Test Plan:
- Basic frame: buffer word0=0x44332211, word1=0x00000055; start with len=5, id=0x2A, tx_ready=1 → buf_rd at addr 0 then addr 1; bytes 11,22,33,44,55 in order; done with done_id=0x2A, done_cnt=5, done_abort=0.
- Zero length: start with len=0 → done in cycle 1 with done_cnt=0; no buf_rd or tx_valid ever asserted.
- Clamp: start with len=1000 → exactly 128 buf_rd pulses, last buf_addr=127; done_cnt=512.
- Backpressure and start while busy: hold tx_ready=0 for 10 cycles on byte 2 → tx_data stays 0x33 with tx_valid high; a start pulse during this time is ignored; the frame still completes with done_cnt=5.
- Abort: abort asserted in the same cycle as the handshake of byte 3 (0x33) of a len=8 frame → done next cycle with done_cnt=3, done_abort=1; tx_valid low thereafter.
- Reset mid-frame: rst during SEND → next cycle all outputs are 0 and busy=0; a subsequent start with len=2 transmits 11,22 correctly.
